mcp_control_fsm_hs: RTL and testbench
=====================================

MCP_CONTROL_FSM_HS -- requirements
Module: mcp_control_fsm_hs

Interface
REQ-001 Parameter CNT_W, default 32: width of retired-instruction counter.
REQ-002 Parameter ALUSEL_W, default 4: width of ALUSel; must be >=4, upper bits beyond [3:0] are driven 0.
REQ-003 CLK  in  1  sole clock, rising edge.
REQ-004 RST  in  1  synchronous, active-high reset.
REQ-005 opcode  in  6  instruction[31:26]; funct  in  6  instruction[5:0], both valid from DECODE onward.
REQ-006 mem_ready  in  1  memory completion strobe for the current mem_req.
REQ-007 mem_req  out  1  memory access request, held until mem_ready.
REQ-008 MtoRFSel, RFDSel, IDSel, ALUIn1Sel  out  1 each; PCSel, ALUIn2Sel  out  2 each: datapath selects.
REQ-009 IRWE, MWE, PCWE, branch, RFWE, DRWE  out  1 each: datapath write enables.
REQ-010 ALUSel  out  ALUSEL_W  ALU operation.
REQ-011 illegal  out  1  sticky trap flag; instr_count  out  CNT_W  retired count; state  out  4  current state code.

Function
REQ-012 Encodings: IDSel 0=PC,1=ALUOut; ALUIn1Sel 0=PC,1=regA; ALUIn2Sel 00=regB,01=const 4,10=sign-ext imm,11=imm<<2; PCSel 00=ALU result,01=ALUOut,10=jump target; RFDSel 0=rt,1=rd; MtoRFSel 0=ALUOut,1=data reg.
REQ-013 ALUSel codes: ADD 0010, SUB 0110, AND 0000, OR 0001, SLT 0111.
REQ-014 States/codes: FETCH 0, DECODE 1, MEMADR 2, MEMRD 3, MEMWB 4, MEMWR 5, EXEC 6, ALUWB 7, BRANCH 8, ADDIEX 9, ADDIWB 10, JUMP 11, TRAP 12; state is registered, outputs are Moore except where noted.
REQ-015 All outputs not listed for a state are 0; ALUSel defaults ADD.
REQ-016 FETCH: mem_req=1, IDSel=0, ALUIn1Sel=0, ALUIn2Sel=01, ALUSel=ADD, PCSel=00; IRWE and PCWE = mem_ready (Mealy); stay until mem_ready=1, then DECODE.
REQ-017 DECODE: ALUIn1Sel=0, ALUIn2Sel=11, ALUSel=ADD; next by opcode: 0x23/0x2B->MEMADR, 0x00->EXEC, 0x04->BRANCH, 0x08->ADDIEX, 0x02->JUMP, other->TRAP.
REQ-018 MEMADR: ALUIn1Sel=1, ALUIn2Sel=10; next MEMRD if opcode 0x23 else MEMWR.
REQ-019 MEMRD: mem_req=1, IDSel=1, DRWE=mem_ready; stay until mem_ready, then MEMWB.
REQ-020 MEMWB: RFWE=1, RFDSel=0, MtoRFSel=1; next FETCH.
REQ-021 MEMWR: mem_req=1, IDSel=1, MWE=1; stay until mem_ready, then FETCH.
REQ-022 EXEC: ALUIn1Sel=1, ALUIn2Sel=00, ALUSel from funct 0x20 ADD, 0x22 SUB, 0x24 AND, 0x25 OR, 0x2A SLT; next ALUWB, or TRAP if funct unlisted.
REQ-023 ALUWB: RFWE=1, RFDSel=1, MtoRFSel=0; next FETCH.
REQ-024 BRANCH: ALUIn1Sel=1, ALUIn2Sel=00, ALUSel=SUB, branch=1, PCSel=01; next FETCH.
REQ-025 ADDIEX: ALUIn1Sel=1, ALUIn2Sel=10, ALUSel=ADD; next ADDIWB. ADDIWB: RFWE=1, RFDSel=0, MtoRFSel=0; next FETCH.
REQ-026 JUMP: PCWE=1, PCSel=10; next FETCH.
REQ-027 TRAP: illegal=1, all enables 0, mem_req=0; absorbing until RST.
REQ-028 instr_count increments by 1 on each exit into FETCH from MEMWB, MEMWR, ALUWB, BRANCH, ADDIWB, JUMP; wraps modulo 2^CNT_W; never increments in TRAP.
REQ-029 mem_ready outside FETCH/MEMRD/MEMWR is ignored.
REQ-030 Latencies with mem_ready asserted on first request cycle: R-type/ADDI/lw 4/4/5 cycles, sw/beq/j 4/3/3.

Reset
REQ-031 RST sampled high at a rising edge forces state=FETCH, instr_count=0, illegal=0 on that edge, from any state including mid-wait; RST overrides mem_ready.
REQ-032 While state=FETCH after reset, mem_req=1 and all write enables 0 until mem_ready.

Verification
REQ-033 Reset, opcode 0x00 funct 0x22, mem_ready tied 1 -> states 0,1,6,7,0; ALUSel=0110 in EXEC; RFWE=1 in ALUWB; instr_count=1.
REQ-034 lw (0x23) with mem_ready delayed 3 cycles in MEMRD -> DRWE pulses exactly once, state 3 held 4 cycles, then 4,0; instr_count +1.
REQ-035 beq (0x04) -> BRANCH with branch=1, PCSel=01, ALUSel=0110, PCWE=0; next FETCH.
REQ-036 opcode 0x3F, then R-type funct 0x27 after reset -> illegal=1 and state=12 both times; instr_count unchanged; held until RST.
REQ-037 CNT_W=4, 16 jumps (0x02) -> instr_count wraps 15->0.
REQ-038 RST asserted while in MEMWR awaiting mem_ready -> next cycle state=0, MWE=0, instr_count=0.

Source files
------------

// File: rtl/mcp_control_fsm_hs.sv
// Multicycle MIPS-subset control FSM: Moore selects registered from next state, one state per cycle.
// FETCH/MEMRD/MEMWR wait on mem_ready; IRWE, PCWE (in FETCH) and DRWE follow mem_ready combinationally.
module mcp_control_fsm_hs #(
  parameter int CNT_W    = 32,
  parameter int ALUSEL_W = 4
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic [5:0]          opcode,
  input  logic [5:0]          funct,
  input  logic                mem_ready,
  output logic                mem_req,
  output logic                MtoRFSel,
  output logic                RFDSel,
  output logic                IDSel,
  output logic                ALUIn1Sel,
  output logic [1:0]          PCSel,
  output logic [1:0]          ALUIn2Sel,
  output logic                IRWE,
  output logic                MWE,
  output logic                PCWE,
  output logic                branch,
  output logic                RFWE,
  output logic                DRWE,
  output logic [ALUSEL_W-1:0] ALUSel,
  output logic                illegal,
  output logic [CNT_W-1:0]    instr_count,
  output logic [3:0]          state
);

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,  S_DECODE = 4'd1,  S_MEMADR = 4'd2,  S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,  S_MEMWR  = 4'd5,  S_EXEC   = 4'd6,  S_ALUWB  = 4'd7,
    S_BRANCH = 4'd8,  S_ADDIEX = 4'd9,  S_ADDIWB = 4'd10, S_JUMP   = 4'd11,
    S_TRAP   = 4'd12
  } state_t;

  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_SLT = 4'b0111;

  typedef struct packed {
    logic       mem_req;
    logic       mtorf;
    logic       rfd;
    logic       ids;
    logic       in1;
    logic [1:0] pcsel;
    logic [1:0] in2;
    logic       mwe;
    logic       pcwe;
    logic       branch;
    logic       rfwe;
    logic [3:0] alu;
    logic       illegal;
  } ctl_t;

  function automatic logic funct_ok(input logic [5:0] fn);
    return (fn == 6'h20) || (fn == 6'h22) || (fn == 6'h24) ||
           (fn == 6'h25) || (fn == 6'h2A);
  endfunction

  function automatic ctl_t f_ctl(input state_t s, input logic [5:0] fn);
    ctl_t c;
    c     = '0;
    c.alu = ALU_ADD;
    case (s)
      S_FETCH:  begin c.mem_req = 1'b1; c.in2 = 2'b01; end
      S_DECODE: c.in2 = 2'b11;
      S_MEMADR: begin c.in1 = 1'b1; c.in2 = 2'b10; end
      S_MEMRD:  begin c.mem_req = 1'b1; c.ids = 1'b1; end
      S_MEMWB:  begin c.rfwe = 1'b1; c.mtorf = 1'b1; end
      S_MEMWR:  begin c.mem_req = 1'b1; c.ids = 1'b1; c.mwe = 1'b1; end
      S_EXEC: begin
        c.in1 = 1'b1;
        case (fn)
          6'h22:   c.alu = ALU_SUB;
          6'h24:   c.alu = ALU_AND;
          6'h25:   c.alu = ALU_OR;
          6'h2A:   c.alu = ALU_SLT;
          default: c.alu = ALU_ADD;
        endcase
      end
      S_ALUWB:  begin c.rfwe = 1'b1; c.rfd = 1'b1; end
      S_BRANCH: begin c.in1 = 1'b1; c.alu = ALU_SUB; c.branch = 1'b1; c.pcsel = 2'b01; end
      S_ADDIEX: begin c.in1 = 1'b1; c.in2 = 2'b10; end
      S_ADDIWB: c.rfwe = 1'b1;
      S_JUMP:   begin c.pcwe = 1'b1; c.pcsel = 2'b10; end
      S_TRAP:   c.illegal = 1'b1;
      default:  c = c;
    endcase
    return c;
  endfunction

  state_t           r_state;
  ctl_t             r_ctl;
  logic [CNT_W-1:0] r_cnt;
  state_t           w_next;
  logic             w_retire;
  logic             w_fetch_done;

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_FETCH:  w_next = mem_ready ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (opcode)
          6'h23, 6'h2B: w_next = S_MEMADR;
          6'h00:        w_next = S_EXEC;
          6'h04:        w_next = S_BRANCH;
          6'h08:        w_next = S_ADDIEX;
          6'h02:        w_next = S_JUMP;
          default:      w_next = S_TRAP;
        endcase
      end
      S_MEMADR: w_next = (opcode == 6'h23) ? S_MEMRD : S_MEMWR;
      S_MEMRD:  w_next = mem_ready ? S_MEMWB : S_MEMRD;
      S_MEMWB:  w_next = S_FETCH;
      S_MEMWR:  w_next = mem_ready ? S_FETCH : S_MEMWR;
      S_EXEC:   w_next = funct_ok(funct) ? S_ALUWB : S_TRAP;
      S_ALUWB:  w_next = S_FETCH;
      S_BRANCH: w_next = S_FETCH;
      S_ADDIEX: w_next = S_ADDIWB;
      S_ADDIWB: w_next = S_FETCH;
      S_JUMP:   w_next = S_FETCH;
      S_TRAP:   w_next = S_TRAP;
      default:  w_next = S_FETCH;
    endcase
  end

  // Only completed instructions retire; unused encodings recovering to FETCH do not count.
  always_comb begin
    w_retire = 1'b0;
    case (r_state)
      S_MEMWB, S_ALUWB, S_BRANCH, S_ADDIWB, S_JUMP: w_retire = 1'b1;
      S_MEMWR:  w_retire = mem_ready;
      default:  w_retire = 1'b0;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state <= S_FETCH;
      r_ctl   <= f_ctl(S_FETCH, funct);
      r_cnt   <= '0;
    end else begin
      r_state <= w_next;
      r_ctl   <= f_ctl(w_next, funct);
      if (w_retire) r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  assign w_fetch_done = (r_state == S_FETCH) && mem_ready;

  assign mem_req     = r_ctl.mem_req;
  assign MtoRFSel    = r_ctl.mtorf;
  assign RFDSel      = r_ctl.rfd;
  assign IDSel       = r_ctl.ids;
  assign ALUIn1Sel   = r_ctl.in1;
  assign PCSel       = r_ctl.pcsel;
  assign ALUIn2Sel   = r_ctl.in2;
  assign IRWE        = w_fetch_done;
  assign MWE         = r_ctl.mwe;
  assign PCWE        = r_ctl.pcwe | w_fetch_done;
  assign branch      = r_ctl.branch;
  assign RFWE        = r_ctl.rfwe;
  assign DRWE        = (r_state == S_MEMRD) && mem_ready;
  assign ALUSel      = ALUSEL_W'(r_ctl.alu);
  assign illegal     = r_ctl.illegal;
  assign instr_count = r_cnt;
  assign state       = r_state;

endmodule

// File: tb/tb_mcp_control_fsm_hs.sv
// Directed bench for mcp_control_fsm_hs with a 4-bit counter and 6-bit ALUSel.
module tb_mcp_control_fsm_hs;
  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic [5:0] opcode = '0;
  logic [5:0] funct = '0;
  logic       mem_ready = 1'b0;
  logic       mem_req, MtoRFSel, RFDSel, IDSel, ALUIn1Sel;
  logic [1:0] PCSel, ALUIn2Sel;
  logic       IRWE, MWE, PCWE, branch, RFWE, DRWE;
  logic [5:0] ALUSel;
  logic       illegal;
  logic [3:0] instr_count;
  logic [3:0] state;

  int total = 0;
  int bad   = 0;

  mcp_control_fsm_hs #(.CNT_W(4), .ALUSEL_W(6)) dut (
    .CLK(CLK), .RST(RST), .opcode(opcode), .funct(funct), .mem_ready(mem_ready),
    .mem_req(mem_req), .MtoRFSel(MtoRFSel), .RFDSel(RFDSel), .IDSel(IDSel),
    .ALUIn1Sel(ALUIn1Sel), .PCSel(PCSel), .ALUIn2Sel(ALUIn2Sel), .IRWE(IRWE),
    .MWE(MWE), .PCWE(PCWE), .branch(branch), .RFWE(RFWE), .DRWE(DRWE),
    .ALUSel(ALUSel), .illegal(illegal), .instr_count(instr_count), .state(state)
  );

  always #5 CLK = ~CLK;

  // Advance one cycle; inputs change and outputs are sampled 1-2ns after the edge.
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset();
    RST = 1'b1;
    tick();
    RST = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    mem_ready = 1'b0;
    do_reset();
    total++; if (state !== 4'd0) begin bad++; $display("FAIL rst_state got=%0d exp=0", state); end
    total++; if (mem_req !== 1'b1) begin bad++; $display("FAIL rst_mem_req got=%b exp=1", mem_req); end
    total++; if ({IRWE, PCWE, MWE, RFWE, DRWE, branch} !== 6'b0) begin bad++; $display("FAIL rst_enables got=%b exp=000000", {IRWE, PCWE, MWE, RFWE, DRWE, branch}); end
    total++; if (illegal !== 1'b0 || instr_count !== 4'd0) begin bad++; $display("FAIL rst_ill_cnt got=%b/%0d exp=0/0", illegal, instr_count); end
    total++; if (ALUSel !== 6'b000010 || ALUIn2Sel !== 2'b01) begin bad++; $display("FAIL rst_fetch_sel got=%b/%b exp=000010/01", ALUSel, ALUIn2Sel); end
    tick(); #1;
    total++; if (state !== 4'd0 || IRWE !== 1'b0) begin bad++; $display("FAIL fetch_hold got=%0d/%b exp=0/0", state, IRWE); end
  endtask

  task automatic test_rtype_sub();
    opcode = 6'h00; funct = 6'h22; mem_ready = 1'b1; #1;
    total++; if (IRWE !== 1'b1 || PCWE !== 1'b1) begin bad++; $display("FAIL rt_fetch_we got=%b%b exp=11", IRWE, PCWE); end
    tick(); #1;
    total++; if (state !== 4'd1 || ALUIn2Sel !== 2'b11 || IRWE !== 1'b0) begin bad++; $display("FAIL rt_decode got=%0d/%b/%b exp=1/11/0", state, ALUIn2Sel, IRWE); end
    tick(); #1;
    total++; if (state !== 4'd6 || ALUSel !== 6'b000110 || ALUIn1Sel !== 1'b1 || ALUIn2Sel !== 2'b00) begin bad++; $display("FAIL rt_exec got=%0d/%b/%b/%b exp=6/000110/1/00", state, ALUSel, ALUIn1Sel, ALUIn2Sel); end
    tick(); #1;
    total++; if (state !== 4'd7 || RFWE !== 1'b1 || RFDSel !== 1'b1 || MtoRFSel !== 1'b0) begin bad++; $display("FAIL rt_aluwb got=%0d/%b%b%b exp=7/110", state, RFWE, RFDSel, MtoRFSel); end
    tick(); #1;
    total++; if (state !== 4'd0 || instr_count !== 4'd1) begin bad++; $display("FAIL rt_retire got=%0d/%0d exp=0/1", state, instr_count); end
  endtask

  task automatic test_lw_wait();
    int pulses;
    pulses = 0;
    opcode = 6'h23; mem_ready = 1'b1;
    tick(); tick(); #1;
    total++; if (state !== 4'd2 || ALUIn2Sel !== 2'b10 || ALUIn1Sel !== 1'b1) begin bad++; $display("FAIL lw_memadr got=%0d/%b exp=2/10", state, ALUIn2Sel); end
    mem_ready = 1'b0;
    tick();
    for (int i = 0; i < 4; i++) begin
      mem_ready = (i == 3); #1;
      total++; if (state !== 4'd3 || mem_req !== 1'b1 || IDSel !== 1'b1) begin bad++; $display("FAIL lw_memrd_%0d got=%0d/%b/%b exp=3/1/1", i, state, mem_req, IDSel); end
      if (DRWE === 1'b1) pulses++;
      tick();
    end
    #1;
    if (DRWE === 1'b1) pulses++;
    total++; if (pulses != 1) begin bad++; $display("FAIL lw_drwe_pulses got=%0d exp=1", pulses); end
    total++; if (state !== 4'd4 || RFWE !== 1'b1 || MtoRFSel !== 1'b1 || RFDSel !== 1'b0) begin bad++; $display("FAIL lw_memwb got=%0d/%b%b%b exp=4/110", state, RFWE, MtoRFSel, RFDSel); end
    tick(); #1;
    total++; if (state !== 4'd0 || instr_count !== 4'd2) begin bad++; $display("FAIL lw_retire got=%0d/%0d exp=0/2", state, instr_count); end
  endtask

  task automatic test_beq();
    opcode = 6'h04; mem_ready = 1'b1;
    tick(); tick(); #1;
    total++; if (state !== 4'd8 || branch !== 1'b1 || PCSel !== 2'b01 || ALUSel !== 6'b000110 || PCWE !== 1'b0) begin bad++; $display("FAIL beq_branch got=%0d/%b/%b/%b/%b exp=8/1/01/000110/0", state, branch, PCSel, ALUSel, PCWE); end
    tick(); #1;
    total++; if (state !== 4'd0 || instr_count !== 4'd3 || branch !== 1'b0) begin bad++; $display("FAIL beq_retire got=%0d/%0d/%b exp=0/3/0", state, instr_count, branch); end
  endtask

  task automatic test_addi();
    opcode = 6'h08; mem_ready = 1'b1;
    tick(); tick(); #1;
    total++; if (state !== 4'd9 || ALUIn2Sel !== 2'b10 || ALUSel !== 6'b000010) begin bad++; $display("FAIL addi_ex got=%0d/%b/%b exp=9/10/000010", state, ALUIn2Sel, ALUSel); end
    tick(); #1;
    total++; if (state !== 4'd10 || RFWE !== 1'b1 || RFDSel !== 1'b0 || MtoRFSel !== 1'b0) begin bad++; $display("FAIL addi_wb got=%0d/%b%b%b exp=10/100", state, RFWE, RFDSel, MtoRFSel); end
    tick(); #1;
    total++; if (state !== 4'd0 || instr_count !== 4'd4) begin bad++; $display("FAIL addi_retire got=%0d/%0d exp=0/4", state, instr_count); end
  endtask

  task automatic test_sw_reset();
    opcode = 6'h2B; mem_ready = 1'b1;
    tick(); tick();
    mem_ready = 1'b0;
    tick(); tick(); #1;
    total++; if (state !== 4'd5 || MWE !== 1'b1 || mem_req !== 1'b1) begin bad++; $display("FAIL sw_wait got=%0d/%b/%b exp=5/1/1", state, MWE, mem_req); end
    mem_ready = 1'b1;
    do_reset();
    total++; if (state !== 4'd0 || MWE !== 1'b0 || instr_count !== 4'd0) begin bad++; $display("FAIL sw_rst got=%0d/%b/%0d exp=0/0/0", state, MWE, instr_count); end
  endtask

  task automatic test_illegal();
    opcode = 6'h3F; mem_ready = 1'b1;
    tick(); tick(); #1;
    total++; if (state !== 4'd12 || illegal !== 1'b1 || instr_count !== 4'd0) begin bad++; $display("FAIL trap_op got=%0d/%b/%0d exp=12/1/0", state, illegal, instr_count); end
    tick(); tick(); tick(); #1;
    total++; if (state !== 4'd12 || illegal !== 1'b1 || {mem_req, IRWE, PCWE, MWE, RFWE, DRWE} !== 6'b0) begin bad++; $display("FAIL trap_hold got=%0d/%b/%b exp=12/1/000000", state, illegal, {mem_req, IRWE, PCWE, MWE, RFWE, DRWE}); end
    do_reset();
    total++; if (illegal !== 1'b0 || state !== 4'd0) begin bad++; $display("FAIL trap_clear got=%b/%0d exp=0/0", illegal, state); end
    opcode = 6'h00; funct = 6'h27;
    tick(); tick(); tick(); #1;
    total++; if (state !== 4'd12 || illegal !== 1'b1 || instr_count !== 4'd0) begin bad++; $display("FAIL trap_funct got=%0d/%b/%0d exp=12/1/0", state, illegal, instr_count); end
    do_reset();
  endtask

  task automatic test_jump_wrap();
    logic [3:0] exp_cnt;
    opcode = 6'h02; mem_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      tick(); tick(); #1;
      total++; if (state !== 4'd11 || PCWE !== 1'b1 || PCSel !== 2'b10) begin bad++; $display("FAIL jump_%0d got=%0d/%b/%b exp=11/1/10", i, state, PCWE, PCSel); end
      tick(); #1;
      exp_cnt = 4'(i + 1);
      total++; if (state !== 4'd0 || instr_count !== exp_cnt) begin bad++; $display("FAIL jump_cnt_%0d got=%0d/%0d exp=0/%0d", i, state, instr_count, exp_cnt); end
    end
  endtask

  initial begin
    test_reset();
    test_rtype_sub();
    test_lw_wait();
    test_beq();
    test_addi();
    test_sw_reset();
    test_illegal();
    test_jump_wrap();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
